// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared opcodes, states and sign helpers for the HI/LO sequencer
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MULDIV_OP_MULT  = 2'b00,
        MULDIV_OP_MULTU = 2'b01,
        MULDIV_OP_DIV   = 2'b10,
        MULDIV_OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'b00,
        MULDIV_ST_MUL  = 2'b01,
        MULDIV_ST_DIV  = 2'b10,
        MULDIV_ST_DONE = 2'b11
    } muldiv_state_e;

    localparam int CNT_W = 5;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return neg_if(v, is_signed & v[31]);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// rtl/muldiv_ctrl_div_radix2.sv - unsigned restoring radix-2 divider, one bit per step
module div_radix2 (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        init,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [63:0] pr_q;
    logic [31:0] dvsr_q;
    logic [32:0] diff;
    logic [63:0] pr_next;

    // Outputs show the partial remainder after the step taken this cycle,
    // so the caller can register the final result on the last step's edge.
    always_comb begin
        diff    = pr_q[63:31] - {1'b0, dvsr_q};
        pr_next = diff[32] ? {pr_q[62:0], 1'b0}
                           : {diff[31:0], pr_q[30:0], 1'b1};
    end

    assign quotient  = pr_next[31:0];
    assign remainder = pr_next[63:32];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pr_q   <= 64'd0;
            dvsr_q <= 32'd0;
        end else if (init) begin
            pr_q   <= {32'd0, dividend};
            dvsr_q <= divisor;
        end else if (step) begin
            pr_q   <= pr_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MULT/MULTU/DIV/DIVU sequencer with stall/advance/flush handshake
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_STAGES = 1,
    parameter int DIV_ITERS  = 32
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        advance_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    muldiv_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    muldiv_op_e       op_q;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             done_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             div_signed;
    logic             div_init;
    logic             div_step;
    logic [31:0]      div_quot;
    logic [31:0]      div_rem;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [63:0]      product;

    assign stall_o = req_i & ~done_q & ~flush_i;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    assign div_signed = ~op_i[0];
    assign div_init   = (state_q == MULDIV_ST_IDLE) & req_i & ~flush_i & op_i[1];
    assign div_step   = (state_q == MULDIV_ST_DIV) & req_i & ~flush_i;

    div_radix2 u_div (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .init      (div_init),
        .step      (div_step),
        .dividend  (abs_if(rs_i, div_signed)),
        .divisor   (abs_if(rt_i, div_signed)),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Sign-extended 64x64 product truncated to 64 bits is exact for both signednesses.
    always_comb begin
        mul_a   = (op_q == MULDIV_OP_MULT) ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
        mul_b   = (op_q == MULDIV_OP_MULT) ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
        product = mul_a * mul_b;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= MULDIV_ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MULDIV_OP_MULT;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (flush_i) begin
            state_q <= MULDIV_ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MULDIV_ST_IDLE: begin
                    if (req_i) begin
                        op_q    <= muldiv_op_e'(op_i);
                        rs_q    <= rs_i;
                        rt_q    <= rt_i;
                        q_neg_q <= div_signed & (rs_i[31] ^ rt_i[31]);
                        r_neg_q <= div_signed & rs_i[31];
                        busy_q  <= 1'b1;
                        if (!op_i[1]) begin
                            state_q <= MULDIV_ST_MUL;
                            cnt_q   <= CNT_W'(MUL_STAGES - 1);
                        end else begin
                            state_q <= MULDIV_ST_DIV;
                            cnt_q   <= CNT_W'(DIV_ITERS - 1);
                        end
                    end
                end
                MULDIV_ST_MUL: begin
                    if (!req_i) begin
                        state_q <= MULDIV_ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= product;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MULDIV_ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MULDIV_ST_DIV: begin
                    if (!req_i) begin
                        state_q <= MULDIV_ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        lo_q    <= neg_if(div_quot, q_neg_q);
                        hi_q    <= neg_if(div_rem, r_neg_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MULDIV_ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MULDIV_ST_DONE: begin
                    if (advance_i || !req_i) begin
                        state_q <= MULDIV_ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MULDIV_ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        req_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        advance_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_ctrl dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .op_i      (op_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .advance_i (advance_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock_i);
        req_i = 1'b1;
        op_i  = op;
        rs_i  = a;
        rt_i  = b;
    endtask

    task automatic wait_done(output int stalls, output bit timeout);
        stalls  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done_o) begin
                timeout = 1'b0;
                break;
            end
            if (stall_o) stalls++;
            @(negedge clock_i);
        end
    endtask

    task automatic retire();
        advance_i = 1'b1;
        @(negedge clock_i);
        advance_i = 1'b0;
        req_i     = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        n_checks++;
        if ({done_o, busy_o, stall_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags actual=%b required=000", {done_o, busy_o, stall_o});
        end
        reset_i = 1'b0;
        @(negedge clock_i);
        #1;
        n_checks++;
        if ({hi_o, lo_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result actual=%h required=0", {hi_o, lo_o});
        end
    endtask

    task automatic test_mult();
        int s;
        bit t;
        start(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(s, t);
        n_checks++;
        if (t || s !== 2) begin
            n_fail++;
            $display("FAIL mult_stall actual=%0d timeout=%0d required=2", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== 64'h00000000_00000001) begin
            n_fail++;
            $display("FAIL mult_result actual=%h required=0000000000000001", {hi_o, lo_o});
        end
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done_stall actual=%b required=0", stall_o);
        end
        retire();
        start(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(s, t);
        n_checks++;
        if (t || s !== 2) begin
            n_fail++;
            $display("FAIL multu_stall actual=%0d timeout=%0d required=2", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin
            n_fail++;
            $display("FAIL multu_result actual=%h required=fffffffe00000001", {hi_o, lo_o});
        end
        retire();
    endtask

    task automatic test_div();
        int s;
        bit t;
        start(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(s, t);
        n_checks++;
        if (t || s !== 33) begin
            n_fail++;
            $display("FAIL div_stall actual=%0d timeout=%0d required=33", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_fail++;
            $display("FAIL div_result actual=%h required=fffffffffffffffd", {hi_o, lo_o});
        end
        retire();
    endtask

    task automatic test_done_hold();
        int s;
        bit t;
        start(OP_DIVU, 32'd100, 32'd7);
        @(negedge clock_i);
        rs_i = 32'd5;
        rt_i = 32'd1;
        wait_done(s, t);
        n_checks++;
        if (t || s !== 32) begin
            n_fail++;
            $display("FAIL divu_stall actual=%0d timeout=%0d required=32", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL divu_result actual=%h required=000000020000000e", {hi_o, lo_o});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_i);
            #1;
            n_checks++;
            if ({done_o, stall_o, hi_o, lo_o} !== {1'b1, 1'b0, 32'd2, 32'd14}) begin
                n_fail++;
                $display("FAIL hold_%0d actual=%b%b_%h_%h required=10_00000002_0000000e",
                         i, done_o, stall_o, hi_o, lo_o);
            end
        end
        advance_i = 1'b1;
        op_i      = OP_MULT;
        rs_i      = 32'hFFFFFFFE;
        rt_i      = 32'd4;
        @(negedge clock_i);
        advance_i = 1'b0;
        #1;
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_done actual=%b required=0", done_o);
        end
        wait_done(s, t);
        n_checks++;
        if (t || s !== 2) begin
            n_fail++;
            $display("FAIL b2b_stall actual=%0d timeout=%0d required=2", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF8) begin
            n_fail++;
            $display("FAIL b2b_result actual=%h required=fffffffffffffff8", {hi_o, lo_o});
        end
        retire();
    endtask

    task automatic test_div_zero();
        int s;
        bit t;
        start(OP_DIVU, 32'h12345678, 32'd0);
        wait_done(s, t);
        n_checks++;
        if (t || {hi_o, lo_o} !== 64'h12345678_FFFFFFFF) begin
            n_fail++;
            $display("FAIL divu_zero actual=%h timeout=%0d required=12345678ffffffff", {hi_o, lo_o}, t);
        end
        retire();
        start(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(s, t);
        n_checks++;
        if (t || {hi_o, lo_o} !== 64'hFFFFFFF9_00000001) begin
            n_fail++;
            $display("FAIL div_zero_neg actual=%h timeout=%0d required=fffffff900000001", {hi_o, lo_o}, t);
        end
        retire();
        start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(s, t);
        n_checks++;
        if (t || {hi_o, lo_o} !== 64'h00000000_80000000) begin
            n_fail++;
            $display("FAIL div_overflow actual=%h timeout=%0d required=0000000080000000", {hi_o, lo_o}, t);
        end
        retire();
    endtask

    task automatic test_flush();
        int s;
        bit t;
        start(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clock_i);
        #1;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_before actual=%b required=1", busy_o);
        end
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall actual=%b required=0", stall_o);
        end
        @(negedge clock_i);
        flush_i = 1'b0;
        req_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({done_o, busy_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_idle_%0d actual=%b required=00", i, {done_o, busy_o});
            end
            @(negedge clock_i);
        end
        start(OP_DIVU, 32'd9, 32'd3);
        wait_done(s, t);
        n_checks++;
        if (t || s !== 33) begin
            n_fail++;
            $display("FAIL flush_restart_stall actual=%0d timeout=%0d required=33", s, t);
        end
        n_checks++;
        if ({hi_o, lo_o} !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL flush_restart_result actual=%h required=0000000000000003", {hi_o, lo_o});
        end
        retire();
    endtask

    task automatic test_reset_mid();
        int s;
        bit t;
        start(OP_DIV, 32'd50, 32'd5);
        repeat (5) @(negedge clock_i);
        reset_i = 1'b1;
        req_i   = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        #1;
        n_checks++;
        if ({done_o, busy_o, stall_o, hi_o, lo_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid actual=%b%b%b_%h_%h required=all zero",
                     done_o, busy_o, stall_o, hi_o, lo_o);
        end
        start(OP_MULT, 32'd3, 32'd5);
        wait_done(s, t);
        n_checks++;
        if (t || s !== 2 || {hi_o, lo_o} !== 64'd15) begin
            n_fail++;
            $display("FAIL reset_mult actual=%h stalls=%0d timeout=%0d required=000000000000000f/2",
                     {hi_o, lo_o}, s, t);
        end
        retire();
    endtask

    initial begin
        reset_i   = 1'b1;
        req_i     = 1'b0;
        op_i      = 2'b00;
        rs_i      = 32'd0;
        rt_i      = 32'd0;
        advance_i = 1'b0;
        flush_i   = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_done_hold();
        test_div_zero();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the HI/LO arithmetic resource used by the EX stage. It accepts MULT/MULTU/DIV/DIVU requests and runs a multi-cycle multiply or an iterative radix-2 divide. It raises a stall to the pipeline controller until the 64-bit result is ready, then holds the result until EX advances. It replaces ad-hoc PC-compare completion tracking with an explicit request/advance/flush handshake.

Parameters:
MUL_STAGES, 1, cycles spent in MUL state (1..3); product registered at the end of the last one
DIV_ITERS, 32, radix-2 iterations; fixed at 32 for 32-bit operands; not to be overridden

Ports:
clock_i  in  1  single clock; all state on rising edge
reset_i  in  1  synchronous, active-high reset
req_i  in  1  EX holds a mul/div instruction this cycle; level, held stable while stall_o=1
op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_i  in  32  operand 1 / dividend
rt_i  in  32  operand 2 / divisor
advance_i  in  1  EX/MEM register captures EX this cycle
flush_i  in  1  exception/ERET flush of EX
stall_o  out  1  stall request to pipeline control
done_o  out  1  hi_o/lo_o valid
hi_o  out  32  MULT: product[63:32]; DIV: remainder
lo_o  out  32  MULT: product[31:0]; DIV: quotient
busy_o  out  1  state is MUL or DIV (debug/perf)

Behaviour:
- Reset (reset_i=1 at edge): state=IDLE, counter=0, operand/result registers=0, done_o=0, hi_o=lo_o=0, busy_o=0. Reset mid-operation aborts without a result.
- States: IDLE, MUL, DIV, DONE.
- stall_o = req_i & ~done_o & ~flush_i (combinational). It is high in the IDLE acceptance cycle.
- IDLE, req_i=1, flush_i=0:
  - Latch op, rs, rt.
  - Go to MUL with counter=MUL_STAGES-1 if op_i[1]=0.
  - Otherwise go to DIV with counter=31. DIV latches |rs| and |rt| for signed ops, raw values for DIVU, plus sign flags.
- MUL: counter decrements; at 0 register the 64-bit product (signed for MULT, unsigned for MULTU) and go to DONE.
- DIV: one restoring shift-subtract step per cycle in div_radix2. At counter 0 go to DONE with the sign-corrected result registered:
  - quotient sign = rs[31]^rt[31]
  - remainder sign = rs[31]
  - DIVU: no correction
- DONE: done_o=1, hi_o/lo_o hold the result. Leave to IDLE on advance_i=1, or when req_i=0. Otherwise stay (downstream stall).
- Latency from first req_i cycle to done_o=1:
  - MULT/MULTU: 1+MUL_STAGES cycles (2 at default)
  - DIV/DIVU: 33 cycles
  - stall_o is high for exactly that many cycles when nothing else stalls.
- Back-to-back: advance_i in DONE returns to IDLE. A new req_i the next cycle starts a fresh operation, so there is never a 0-cycle result reuse.
- flush_i=1 in any state: next state IDLE, done_o=0 next cycle, no result. flush_i in IDLE blocks acceptance.
- req_i falling in MUL/DIV without flush: treated as abort; return to IDLE.
- Divide by zero (no trap):
  - DIVU: lo=0xFFFFFFFF, hi=rs
  - DIV: quotient magnitude 0xFFFFFFFF sign-fixed (rs<0 gives lo=0x00000001), hi=rs
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Operand changes while stall_o=1 are ignored; the latched copies are used.

Decomposition:
- defines.vh gets MULDIV_OP_MULT/MULTU/DIV/DIVU (2-bit) and MULDIV_ST_IDLE/MUL/DIV/DONE.
- One sub-module, div_radix2:
  - Ports: clock_i, reset_i, init, step, dividend[31:0], divisor[31:0], quotient[31:0], remainder[31:0].
  - Holds a 64-bit partial-remainder register; unsigned only.
- Sign handling and sequencing stay in muldiv_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0xFFFFFFFF -> stall_o 2 cycles, done_o, hi=0x00000000 lo=0x00000001. MULTU same operands -> hi=0xFFFFFFFE lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> stall_o exactly 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV by zero: DIVU 0x12345678/0 -> lo=0xFFFFFFFF hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- flush_i at cycle 10 of a DIV -> next cycle IDLE, done_o stays 0. A new DIVU 9/3 then completes in 33 cycles with lo=3 hi=0.
- DONE held with advance_i=0 for 5 cycles -> done_o and result stable, stall_o=0. advance_i=1 with req_i=1 for a new MULT -> IDLE, then restart, stall_o high 2 cycles.
- reset_i asserted mid-DIV -> next cycle all outputs 0, state IDLE. A MULT 3*5 afterwards -> lo=15 hi=0.
